branch_predict_unit: RTL and testbench



---
 rtl/branch_predict_unit_pkg.sv | 52 +++++
 rtl/branch_predict_unit_cond_eval.sv | 47 ++++
 rtl/branch_predict_unit.sv | 182 ++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predict_unit_pkg.sv
// Shared types for the branch predictor: condition/opcode encodings,
// the one-bit signal enum and the predictor entry layout.
package core_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int ENTRIES_DEF = 64;
    localparam int TAG_W_DEF   = 8;
    localparam int CNT_W_DEF   = 2;

    // Branch conditions follow the RV32 funct3 encoding; BR_NONE marks a non-branch.
    typedef enum logic [2:0] {
        BEQ     = 3'b000,
        BNE     = 3'b001,
        BR_NONE = 3'b010,
        BLT     = 3'b100,
        BGE     = 3'b101,
        BLTU    = 3'b110,
        BGEU    = 3'b111
    } br_cond_e;

    typedef enum logic [6:0] {
        LUI      = 7'b0110111,
        AUIPC    = 7'b0010111,
        JUMP     = 7'b1101111,
        JUMP_R   = 7'b1100111,
        BRANCH   = 7'b1100011,
        LOAD     = 7'b0000011,
        STORE    = 7'b0100011,
        OP_IMM   = 7'b0010011,
        OP       = 7'b0110011,
        MISC_MEM = 7'b0001111,
        SYSTEM   = 7'b1110011
    } rv32_opcodes_e;

    typedef enum logic {
        SIG_LOW  = 1'b0,
        SIG_HIGH = 1'b1
    } onebit_sig_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [CNT_W_DEF-1:0] cnt;
        logic [XLEN_DEF-1:0]  target;
    } bp_entry_t;

    function automatic logic is_branch_cond(input br_cond_e c);
        return (c == BEQ) || (c == BNE) || (c == BLT) ||
               (c == BGE) || (c == BLTU) || (c == BGEU);
    endfunction

endpackage

// File: rtl/branch_predict_unit_cond_eval.sv
// Combinational resolve of a branch/jump: outcome plus instruction class.
module branch_cond_eval
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  br_cond_e        br_cond_i,
    input  rv32_opcodes_e   opcode_i,
    output logic            taken_o,
    output logic            is_branch_o,
    output logic            is_jump_o,
    output logic            is_cf_o
);

    logic eq;
    logic lt_s;
    logic lt_u;
    logic jump_op;

    assign eq      = (a_i == b_i);
    assign lt_s    = ($signed(a_i) < $signed(b_i));
    assign lt_u    = (a_i < b_i);
    assign jump_op = (opcode_i == JUMP) || (opcode_i == JUMP_R);

    // A real branch condition wins over the opcode; otherwise only jumps are taken.
    always_comb begin
        taken_o     = 1'b0;
        is_branch_o = is_branch_cond(br_cond_i);
        is_jump_o   = 1'b0;
        unique case (br_cond_i)
            BEQ:     taken_o = eq;
            BNE:     taken_o = !eq;
            BLT:     taken_o = lt_s;
            BGE:     taken_o = !lt_s;
            BLTU:    taken_o = lt_u;
            BGEU:    taken_o = !lt_u;
            default: begin
                taken_o   = jump_op;
                is_jump_o = jump_op;
            end
        endcase
        is_cf_o = is_branch_o || is_jump_o;
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped predictor (tag + saturating counter + target) with execute
// stage resolve, mispredict redirect and branch/mispredict statistics.
module branch_predict_unit
    import core_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ENTRIES = ENTRIES_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] pc_f_i,
    output onebit_sig_e     pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    input  logic            ex_valid_i,
    input  logic            stall_i,
    input  logic            flush_tbl_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  br_cond_e        br_cond_i,
    input  rv32_opcodes_e   opcode_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            ex_pred_taken_i,
    input  logic [XLEN-1:0] ex_pred_target_i,
    output onebit_sig_e     branch_taken_o,
    output logic            mispredict_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [31:0]     br_count_o,
    output logic [31:0]     mp_count_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + TAG_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1 << (CNT_W - 1));

    logic             valid_q [ENTRIES];
    logic             valid_d [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [TAG_W-1:0] tag_d   [ENTRIES];
    logic [CNT_W-1:0] cnt_q   [ENTRIES];
    logic [CNT_W-1:0] cnt_d   [ENTRIES];
    logic [XLEN-1:0]  tgt_q   [ENTRIES];
    logic [XLEN-1:0]  tgt_d   [ENTRIES];

    logic [31:0] br_cnt_q, br_cnt_d;
    logic [31:0] mp_cnt_q, mp_cnt_d;

    logic [IDX_W-1:0] f_idx, ex_idx;
    logic [TAG_W-1:0] f_tag, ex_tag;
    logic             f_hit, ex_hit;
    logic             f_taken;

    logic taken, is_branch, is_jump, is_cf;
    logic upd;
    logic [CNT_W-1:0] cnt_inc, cnt_dec;

    logic unused_pc_bits;

    assign unused_pc_bits = ^{pc_f_i[1:0], pc_f_i[XLEN-1:TAG_HI+1],
                              ex_pc_i[1:0], ex_pc_i[XLEN-1:TAG_HI+1]};

    branch_cond_eval #(.XLEN(XLEN)) u_cond (
        .a_i         (a_i),
        .b_i         (b_i),
        .br_cond_i   (br_cond_i),
        .opcode_i    (opcode_i),
        .taken_o     (taken),
        .is_branch_o (is_branch),
        .is_jump_o   (is_jump),
        .is_cf_o     (is_cf)
    );

    assign f_idx  = pc_f_i[TAG_LO-1:2];
    assign f_tag  = pc_f_i[TAG_HI:TAG_LO];
    assign ex_idx = ex_pc_i[TAG_LO-1:2];
    assign ex_tag = ex_pc_i[TAG_HI:TAG_LO];

    // Fetch-side lookup reads registered contents only (no same-cycle bypass).
    assign f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_taken       = f_hit && cnt_q[f_idx][CNT_W-1];
    assign pred_taken_o  = onebit_sig_e'(f_taken);
    assign pred_target_o = f_taken ? tgt_q[f_idx] : '0;

    assign ex_hit  = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign cnt_inc = (cnt_q[ex_idx] == CNT_MAX) ? CNT_MAX : cnt_q[ex_idx] + CNT_W'(1);
    assign cnt_dec = (cnt_q[ex_idx] == '0) ? '0 : cnt_q[ex_idx] - CNT_W'(1);

    assign branch_taken_o = onebit_sig_e'(taken);
    assign mispredict_o   = ex_valid_i &&
                            ((taken != ex_pred_taken_i) ||
                             (taken && (target_i != ex_pred_target_i)));
    assign redirect_pc_o  = taken ? target_i : ex_pc_i + XLEN'(4);

    assign upd = ex_valid_i && !stall_i;

    // Table next-state: flush clears valid bits and drops any update in the same cycle.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        if (flush_tbl_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else if (upd) begin
            if (is_branch) begin
                if (ex_hit) begin
                    if (taken) begin
                        cnt_d[ex_idx] = cnt_inc;
                        tgt_d[ex_idx] = target_i;
                    end else begin
                        cnt_d[ex_idx] = cnt_dec;
                    end
                end else if (taken) begin
                    valid_d[ex_idx] = 1'b1;
                    tag_d[ex_idx]   = ex_tag;
                    cnt_d[ex_idx]   = CNT_WEAK;
                    tgt_d[ex_idx]   = target_i;
                end
            end else if (is_jump) begin
                valid_d[ex_idx] = 1'b1;
                tag_d[ex_idx]   = ex_tag;
                cnt_d[ex_idx]   = CNT_MAX;
                tgt_d[ex_idx]   = target_i;
            end else if (ex_hit) begin
                // A non-control instruction aliasing onto a live entry evicts it.
                valid_d[ex_idx] = 1'b0;
            end
        end
    end

    // Statistics next-state: saturating counts, frozen by stall and flush.
    always_comb begin
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (!flush_tbl_i && upd) begin
            if (is_cf && (br_cnt_q != '1)) begin
                br_cnt_d = br_cnt_q + 32'd1;
            end
            if (mispredict_o && (mp_cnt_q != '1)) begin
                mp_cnt_d = mp_cnt_q + 32'd1;
            end
        end
    end

    // Table registers with synchronous reset to an all-invalid, all-zero state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                cnt_q[i]   <= '0;
                tgt_q[i]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign br_count_o = br_cnt_q;
    assign mp_count_o = mp_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed literal checks plus randomized
// traffic compared every cycle against a behavioural table model.
module tb_branch_predict_unit;
    import core_pkg::*;

    logic          clk;
    logic          rst;
    logic [31:0]   pc_f;
    onebit_sig_e   pred_taken;
    logic [31:0]   pred_target;
    logic          ex_valid;
    logic          stall;
    logic          flush;
    logic [31:0]   ex_pc;
    logic [31:0]   a, b;
    br_cond_e      br_cond;
    rv32_opcodes_e opcode;
    logic [31:0]   target;
    logic          ex_ptk;
    logic [31:0]   ex_ptgt;
    onebit_sig_e   branch_taken;
    logic          mispredict;
    logic [31:0]   redirect_pc;
    logic [31:0]   br_count;
    logic [31:0]   mp_count;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    branch_predict_unit dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .pc_f_i           (pc_f),
        .pred_taken_o     (pred_taken),
        .pred_target_o    (pred_target),
        .ex_valid_i       (ex_valid),
        .stall_i          (stall),
        .flush_tbl_i      (flush),
        .ex_pc_i          (ex_pc),
        .a_i              (a),
        .b_i              (b),
        .br_cond_i        (br_cond),
        .opcode_i         (opcode),
        .target_i         (target),
        .ex_pred_taken_i  (ex_ptk),
        .ex_pred_target_i (ex_ptgt),
        .branch_taken_o   (branch_taken),
        .mispredict_o     (mispredict),
        .redirect_pc_o    (redirect_pc),
        .br_count_o       (br_count),
        .mp_count_o       (mp_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit          m_valid [64];
    int          m_tag   [64];
    int          m_cnt   [64];
    logic [31:0] m_tgt   [64];
    longint      m_br = 0;
    longint      m_mp = 0;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 8) % 256);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_tgt(input logic [31:0] pc);
        return m_pred(pc) ? m_tgt[idx_of(pc)] : 32'd0;
    endfunction

    function automatic bit m_is_br();
        return br_cond == BEQ || br_cond == BNE || br_cond == BLT ||
               br_cond == BGE || br_cond == BLTU || br_cond == BGEU;
    endfunction

    function automatic bit m_is_jmp();
        return !m_is_br() && (opcode == JUMP || opcode == JUMP_R);
    endfunction

    function automatic bit m_taken();
        case (br_cond)
            BEQ:     return a == b;
            BNE:     return a != b;
            BLT:     return $signed(a) < $signed(b);
            BGE:     return $signed(a) >= $signed(b);
            BLTU:    return a < b;
            BGEU:    return a >= b;
            default: return opcode == JUMP || opcode == JUMP_R;
        endcase
    endfunction

    function automatic bit m_misp();
        bit t;
        t = m_taken();
        return ex_valid && ((t != ex_ptk) || (t && target != ex_ptgt));
    endfunction

    function automatic logic [31:0] m_redirect();
        return m_taken() ? target : ex_pc + 32'd4;
    endfunction

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    always @(posedge clk) begin
        int i;
        bit t;
        i = idx_of(ex_pc);
        t = m_taken();
        if (rst) begin
            for (int k = 0; k < 64; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_cnt[k] = 0; m_tgt[k] = 0;
            end
            m_br = 0;
            m_mp = 0;
        end else if (flush) begin
            for (int k = 0; k < 64; k++) m_valid[k] = 0;
        end else if (ex_valid && !stall) begin
            if (m_is_br() || m_is_jmp()) m_br++;
            if (m_misp()) m_mp++;
            if (m_is_br()) begin
                if (m_hit(ex_pc)) begin
                    if (t) begin
                        m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
                        m_tgt[i] = target;
                    end else begin
                        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
                    end
                end else if (t) begin
                    m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_cnt[i] = 2; m_tgt[i] = target;
                end
            end else if (m_is_jmp()) begin
                m_valid[i] = 1; m_tag[i] = tag_of(ex_pc); m_cnt[i] = 3; m_tgt[i] = target;
            end else if (m_hit(ex_pc)) begin
                m_valid[i] = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: DUT outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_pred_taken",  32'(pred_taken),   32'(m_pred(pc_f)));
            chk("m_pred_target", pred_target,       m_pred_tgt(pc_f));
            chk("m_br_taken",    32'(branch_taken), 32'(m_taken()));
            chk("m_mispredict",  32'(mispredict),   32'(m_misp()));
            chk("m_redirect",    redirect_pc,       m_redirect());
            chk("m_br_count",    br_count,          sat32(m_br));
            chk("m_mp_count",    mp_count,          sat32(m_mp));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] fpc);
        pc_f = fpc; ex_valid = 0; stall = 0; flush = 0;
        ex_pc = 0; a = 0; b = 0; br_cond = BR_NONE; opcode = OP;
        target = 0; ex_ptk = 0; ex_ptgt = 0;
    endtask

    task automatic ex(input logic [31:0] pc, input logic [31:0] av, input logic [31:0] bv,
                      input br_cond_e c, input rv32_opcodes_e op, input logic [31:0] tg,
                      input logic ptk, input logic [31:0] ptg);
        ex_valid = 1; stall = 0; flush = 0;
        ex_pc = pc; a = av; b = bv; br_cond = c; opcode = op;
        target = tg; ex_ptk = ptk; ex_ptgt = ptg;
    endtask

    rv32_opcodes_e ops [11] = '{LUI, AUIPC, JUMP, JUMP_R, BRANCH, LOAD, STORE,
                                OP_IMM, OP, MISC_MEM, SYSTEM};

    function automatic logic [31:0] rnd_pc();
        return (32'($urandom_range(0, 1)) << 8) | (32'($urandom_range(0, 7)) << 2) |
               (32'($urandom_range(0, 1)) << 20);
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'($urandom_range(0, 3));
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        idle(32'h0);
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        chk_en = 1;

        idle(32'h100); #1;
        chk("rst_pred_taken", 32'(pred_taken), 0);
        chk("rst_pred_target", pred_target, 0);
        chk("rst_br_count", br_count, 0);
        chk("rst_mp_count", mp_count, 0);

        cyc(); ex(32'h100, 5, 5, BEQ, BRANCH, 32'h140, 0, 0); #1;
        chk("beq_taken", 32'(branch_taken), 1);
        chk("beq_misp", 32'(mispredict), 1);
        chk("beq_redirect", redirect_pc, 32'h140);

        cyc(); idle(32'h100); #1;
        chk("alloc_pred", 32'(pred_taken), 1);
        chk("alloc_target", pred_target, 32'h140);
        chk("alloc_br", br_count, 1);
        chk("alloc_mp", mp_count, 1);

        cyc(); ex(32'h100, 5, 6, BEQ, BRANCH, 32'h140, 1, 32'h140); #1;
        chk("nt1_misp", 32'(mispredict), 1);
        chk("nt1_redirect", redirect_pc, 32'h104);
        cyc(); ex(32'h100, 5, 6, BEQ, BRANCH, 32'h140, 0, 0); #1;
        chk("nt2_misp", 32'(mispredict), 0);
        cyc(); idle(32'h100); #1;
        chk("cnt0_pred", 32'(pred_taken), 0);
        chk("cnt0_target", pred_target, 0);
        cyc(); ex(32'h100, 5, 6, BEQ, BRANCH, 32'h140, 0, 0);
        cyc(); ex(32'h100, 7, 7, BEQ, BRANCH, 32'h140, 0, 0);
        cyc(); idle(32'h100); #1;
        chk("sat0_pred", 32'(pred_taken), 0);
        chk("sat0_br", br_count, 5);
        chk("sat0_mp", mp_count, 3);

        cyc(); ex(32'h180, 32'hFFFF_FFFF, 1, BLT, BRANCH, 32'h1C0, 1, 32'h1C0); #1;
        chk("blt_taken", 32'(branch_taken), 1);
        chk("blt_misp", 32'(mispredict), 0);
        cyc(); ex(32'h180, 32'hFFFF_FFFF, 1, BLTU, BRANCH, 32'h1C0, 0, 0); #1;
        chk("bltu_taken", 32'(branch_taken), 0);
        chk("bltu_redirect", redirect_pc, 32'h184);

        cyc(); ex(32'h200, 0, 0, BR_NONE, JUMP_R, 32'h300, 0, 0); #1;
        chk("jr1_misp", 32'(mispredict), 1);
        cyc(); idle(32'h200); #1;
        chk("jr1_target", pred_target, 32'h300);
        cyc(); ex(32'h200, 0, 0, BR_NONE, JUMP_R, 32'h380, 1, 32'h300); #1;
        chk("jr2_misp", 32'(mispredict), 1);
        chk("jr2_redirect", redirect_pc, 32'h380);
        cyc(); idle(32'h200); #1;
        chk("jr2_target", pred_target, 32'h380);
        chk("jr2_br", br_count, 9);
        chk("jr2_mp", mp_count, 5);

        cyc(); ex(32'h200, 1, 2, BR_NONE, OP, 0, 0, 0);
        cyc(); idle(32'h200); #1;
        chk("alias_pred", 32'(pred_taken), 0);

        cyc(); ex(32'h240, 3, 3, BEQ, BRANCH, 32'h280, 0, 0); stall = 1; #1;
        chk("stall_misp", 32'(mispredict), 1);
        cyc(); idle(32'h240); #1;
        chk("stall_pred", 32'(pred_taken), 0);
        chk("stall_br", br_count, 9);
        chk("stall_mp", mp_count, 5);

        cyc(); ex(32'h300, 0, 0, BR_NONE, JUMP, 32'h400, 0, 0);
        cyc(); idle(32'h300); #1;
        chk("jal_pred", 32'(pred_taken), 1);
        cyc(); ex(32'h240, 3, 3, BEQ, BRANCH, 32'h280, 0, 0); flush = 1;
        cyc(); idle(32'h300); #1;
        chk("flush_pred", 32'(pred_taken), 0);
        chk("flush_br", br_count, 10);
        chk("flush_mp", mp_count, 6);
        cyc(); idle(32'h240); #1;
        chk("flush_drop", 32'(pred_taken), 0);

        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst      = ($urandom_range(0, 299) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            ex_valid = ($urandom_range(0, 4) != 0);
            pc_f     = rnd_pc();
            ex_pc    = rnd_pc();
            a        = rnd_opnd();
            b        = ($urandom_range(0, 3) == 0) ? a : rnd_opnd();
            br_cond  = br_cond_e'(3'($urandom_range(0, 7)));
            if (m_is_br() && $urandom_range(0, 9) != 0) opcode = BRANCH;
            else opcode = ops[$urandom_range(0, 10)];
            target   = 32'($urandom_range(1, 6)) << 6;
            if ($urandom_range(0, 1) == 0) begin
                ex_ptk  = m_pred(ex_pc);
                ex_ptgt = m_pred_tgt(ex_pc);
            end else begin
                ex_ptk  = 1'($urandom_range(0, 1));
                ex_ptgt = 32'($urandom_range(1, 6)) << 6;
            end
        end

        cyc();
        idle(32'h0);
        cyc();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
